// File: rtl/seq_decoder_pkg.sv
// Shared types for the sequencing one-hot decoder.
//   state_t : controller states (idle, holding a direct select, scanning)
//   mode_t  : request mode carried on the 'mode' input
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

endpackage

// File: rtl/seq_decoder_onehot_decode.sv
// Combinational binary-to-one-hot decoder.
//   i_index  : N-bit binary index
//   o_onehot : OUT_W-bit vector with only bit i_index set
module onehot_decode #(
  parameter int N     = 3,
  parameter int OUT_W = 2**N
) (
  input  logic [N-1:0]     i_index,
  output logic [OUT_W-1:0] o_onehot
);

  // Compare the index against every bit position.
  always_comb begin
    o_onehot = {OUT_W{1'b0}};
    for (int i = 0; i < OUT_W; i++) begin
      o_onehot[i] = (i_index == N'(i));
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// Sequencing one-hot decoder.
// DIRECT requests drive y = 1<<D until the next request; SCAN requests walk
// the single set bit through all OUT_W positions starting at D, holding each
// for dwell+1 cycles, then clear y and pulse scan_done.
//   clk, rst (sync, active-high), en (low aborts/clears)
//   mode, in_valid, D, dwell : request inputs, sampled on accept
//   in_ready                 : combinational, low while scanning or in reset
//   y, y_valid, scan_done    : registered outputs
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int OUT_W   = 2**N,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       D,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic               y_valid,
  output logic               scan_done
);

  localparam logic [N-1:0] LP_LAST = N'(OUT_W - 1);

  state_t             r_state;
  logic [N-1:0]       r_pos;
  logic [N-1:0]       r_visit;   // positions already completed in this scan
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;     // cycles spent at the current position, minus one
  logic [OUT_W-1:0]   r_y;
  logic               r_y_valid;
  logic               r_scan_done;

  state_t             w_state_nx;
  logic [N-1:0]       w_pos_nx;
  logic [N-1:0]       w_visit_nx;
  logic [DWELL_W-1:0] w_dwell_nx;
  logic [DWELL_W-1:0] w_cnt_nx;
  logic [N-1:0]       w_idx;
  logic               w_load_y;
  logic               w_clear_y;
  logic               w_done_nx;
  logic [OUT_W-1:0]   w_dec;
  logic [OUT_W-1:0]   w_y_nx;
  logic               w_accept;
  logic [N-1:0]       w_pos_inc;

  assign in_ready  = (r_state != ST_SCAN) && !rst;
  assign w_accept  = in_valid && in_ready && en;
  // Natural N-bit wrap gives the modulo-OUT_W step.
  assign w_pos_inc = r_pos + N'(1);

  // Single decoder feeds every y value; the index is muxed ahead of it.
  onehot_decode #(.N(N), .OUT_W(OUT_W)) u_dec (
    .i_index  (w_idx),
    .o_onehot (w_dec)
  );

  // Next-state and datapath control.
  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_visit_nx = r_visit;
    w_dwell_nx = r_dwell;
    w_cnt_nx   = r_cnt;
    w_idx      = r_pos;
    w_load_y   = 1'b0;
    w_clear_y  = 1'b0;
    w_done_nx  = 1'b0;
    if (!en) begin
      // Abort without completion pulse.
      w_state_nx = ST_IDLE;
      w_clear_y  = 1'b1;
      w_cnt_nx   = {DWELL_W{1'b0}};
      w_visit_nx = {N{1'b0}};
    end else if (w_accept) begin
      w_idx    = D;
      w_load_y = 1'b1;
      if (mode == MODE_SCAN) begin
        w_state_nx = ST_SCAN;
        w_pos_nx   = D;
        w_dwell_nx = dwell;
        w_cnt_nx   = {DWELL_W{1'b0}};
        w_visit_nx = {N{1'b0}};
      end else begin
        w_state_nx = ST_DRIVE;
      end
    end else begin
      case (r_state)
        ST_SCAN: begin
          // Counting up to r_dwell (not dwell+1) keeps max dwell inside DWELL_W bits.
          if (r_cnt == r_dwell) begin
            if (r_visit == LP_LAST) begin
              w_state_nx = ST_IDLE;
              w_clear_y  = 1'b1;
              w_done_nx  = 1'b1;
            end else begin
              w_pos_nx   = w_pos_inc;
              w_idx      = w_pos_inc;
              w_load_y   = 1'b1;
              w_visit_nx = r_visit + N'(1);
              w_cnt_nx   = {DWELL_W{1'b0}};
            end
          end else begin
            w_cnt_nx = r_cnt + DWELL_W'(1);
          end
        end
        default: begin
          w_state_nx = r_state;
        end
      endcase
    end
  end

  // Next output value: clear, reload from decoder, or hold.
  always_comb begin
    w_y_nx = r_y;
    if (w_clear_y) begin
      w_y_nx = {OUT_W{1'b0}};
    end else if (w_load_y) begin
      w_y_nx = w_dec;
    end else begin
      w_y_nx = r_y;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pos       <= {N{1'b0}};
      r_visit     <= {N{1'b0}};
      r_dwell     <= {DWELL_W{1'b0}};
      r_cnt       <= {DWELL_W{1'b0}};
      r_y         <= {OUT_W{1'b0}};
      r_y_valid   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pos       <= w_pos_nx;
      r_visit     <= w_visit_nx;
      r_dwell     <= w_dwell_nx;
      r_cnt       <= w_cnt_nx;
      r_y         <= w_y_nx;
      r_y_valid   <= |w_y_nx;
      r_scan_done <= w_done_nx;
    end
  end

  assign y         = r_y;
  assign y_valid   = r_y_valid;
  assign scan_done = r_scan_done;

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 SHALL have parameter N, default 3, meaning select width.
REQ-002 SHALL have parameter OUT_W, default 2**N, meaning one-hot output width; it is derived and never overridden.
REQ-003 SHALL have parameter DWELL_W, default 4, meaning dwell counter width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-006 SHALL have port en, input, 1, block enable; low aborts and clears the output.
REQ-007 SHALL have port mode, input, 1, operating mode: 0 = DIRECT, 1 = SCAN; sampled only on accept.
REQ-008 SHALL have port in_valid, input, 1, request valid.
REQ-009 SHALL have port in_ready, output, 1, request ready.
REQ-010 SHALL have port D, input, N, select index (DIRECT) or start index (SCAN).
REQ-011 SHALL have port dwell, input, DWELL_W, extra cycles per scan position; sampled on accept.
REQ-012 SHALL have port y, output, OUT_W, registered one-hot or all-zero output.
REQ-013 SHALL have port y_valid, output, 1, high when y is non-zero.
REQ-014 SHALL have port scan_done, output, 1, one-cycle pulse on scan completion.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE and SCAN.
REQ-016 An accept SHALL be in_valid && in_ready && en.
REQ-017 in_ready SHALL equal (state != SCAN) && !rst, combinationally.
REQ-018 On a DIRECT accept, y SHALL equal 1<<D and y_valid SHALL be 1 on the next cycle (latency 1); state goes to DRIVE.
REQ-019 DRIVE SHALL hold y until the next accept, which replaces y one cycle later with no intervening zero cycle.
REQ-020 On a SCAN accept, the block SHALL latch D as position p and latch dwell.
REQ-021 On a SCAN accept, y SHALL equal 1<<p on the next cycle; state goes to SCAN.
REQ-022 In SCAN, each position SHALL be held for dwell+1 cycles; p then increments modulo OUT_W, wrapping from OUT_W-1 to 0.
REQ-023 SCAN SHALL visit exactly OUT_W positions; after the last hold, y becomes 0, y_valid 0, and scan_done is 1 for one cycle, with state going to IDLE.
REQ-024 A scan from start index s SHALL take exactly OUT_W*(dwell+1) cycles from the first non-zero y to scan_done.
REQ-025 Changes to mode, D or dwell during SCAN SHALL be ignored.
REQ-026 in_valid during SCAN SHALL not be accepted.
REQ-027 en low in any state SHALL make y 0, y_valid 0 and state IDLE on the next cycle, with no scan_done.
REQ-028 en low with in_valid high SHALL produce no accept.
REQ-029 dwell=0 SHALL give one cycle per position.
REQ-030 The maximum dwell SHALL give 2**DWELL_W cycles per position with no counter overflow.
REQ-031 y SHALL never have more than one bit set in any cycle.
REQ-032 scan_done and y_valid SHALL never both be high in the same cycle.

Reset
REQ-033 When rst is high, y SHALL be 0, y_valid 0, scan_done 0, the state IDLE, and the dwell counter and position register 0.
REQ-034 While rst is high, in_ready SHALL be 0.
REQ-035 Reset SHALL override en and in_valid in the same cycle.
REQ-036 Reset mid-scan SHALL abort the scan with no scan_done pulse.

Structure
REQ-037 Package seq_decoder_pkg SHALL hold the state enum (IDLE, DRIVE, SCAN) and the mode enum (DIRECT=0, SCAN=1).
REQ-038 One combinational sub-module, onehot_decode (parameter N; input index, output OUT_W one-hot), SHALL generate all y values.
REQ-039 The dwell counter, position register and FSM SHALL reside in seq_decoder.

Verification
REQ-040 (N=3) Reset, then DIRECT accept D=5 -> y=8'b0010_0000 and y_valid=1 the next cycle; y holds until the next accept.
REQ-041 DIRECT back-to-back accepts D=0 then D=7 -> y=8'b0000_0001, then 8'b1000_0000 with no zero cycle between.
REQ-042 SCAN accept D=6, dwell=1 -> y walks bits 6,7,0,1,...,5, two cycles each (16 cycles); scan_done pulses once; y=0 after; in_ready=0 throughout the scan.
REQ-043 SCAN with dwell=0 and in_valid held high with D=2 -> 8 single-cycle positions; no accept until in_ready returns to 1 after scan_done.
REQ-044 en dropped mid-scan at position 3 -> y=0 and IDLE next cycle; scan_done stays 0 afterwards.
REQ-045 rst asserted together with in_valid && en -> no accept; all outputs 0; in_ready=0 while rst is high.
